boreal_bus_initiator: RTL

Queued bus master that drives one master port of the SoC interconnect (req/wr/addr/wdata/strb out; rdata/ack/err in). It accepts read/write commands on a valid/ready interface, issues them one at a time, and returns one response per command on a valid/ready interface. It guards each transfer with a bus timeout, rejects misaligned addresses locally, and keeps error statistics. Intended users are the DMA and external-host bridge in front of the public port.

---
 rtl/boreal_bus_initiator_if.sv | 47 ++++
 rtl/boreal_bus_initiator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/boreal_bus_initiator_if.sv
// Command, response and interconnect master signals of the queued bus initiator.
// The master modport is the initiator's view; slave is the view of everything around it.
interface boreal_bus_initiator_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_wr;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;

   logic          m_req;
   logic          m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [SW-1:0] m_strb;
   logic [DW-1:0] m_rdata;
   logic          m_ack;
   logic          m_err;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_strb,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  rsp_ready,
      output m_req, m_wr, m_addr, m_wdata, m_strb,
      input  m_rdata, m_ack, m_err
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_strb,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output rsp_ready,
      input  m_req, m_wr, m_addr, m_wdata, m_strb,
      output m_rdata, m_ack, m_err
   );
endinterface

// File: rtl/boreal_bus_initiator.sv
// Queued bus master: FIFOs commands, issues them one at a time with a bus timeout,
// rejects misaligned addresses locally and returns one response per command.
module boreal_bus_initiator #(
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned TIMEOUT   = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   boreal_bus_initiator_if.master bus,
   output logic                  busy,
   output logic [7:0]            err_count
);
   localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned TCNT_W = $clog2(TIMEOUT) + 1;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   state_t             state_q, state_d;
   cmd_t               fifo_q [CMD_DEPTH];
   cmd_t               cmd_in, head;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               push, pop;

   logic               m_req_q, m_req_d;
   logic               m_wr_q, m_wr_d;
   logic [31:0]        m_addr_q, m_addr_d;
   logic [31:0]        m_wdata_q, m_wdata_d;
   logic [3:0]         m_strb_q, m_strb_d;
   logic [TCNT_W-1:0]  tcnt_q, tcnt_d;

   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;
   logic               rsp_to_q, rsp_to_d;

   logic               busy_q, busy_d;
   logic [7:0]         err_cnt_q, err_cnt_d;
   logic               err_inc;

   assign cmd_in = '{wr: bus.cmd_wr, addr: bus.cmd_addr, wdata: bus.cmd_wdata, strb: bus.cmd_strb};
   assign head   = fifo_q[rd_ptr_q];
   assign push   = bus.cmd_valid && cmd_ready_q;

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= cmd_in;
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      err_inc     = 1'b0;
      m_req_d     = m_req_q;
      m_wr_d      = m_wr_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      m_strb_d    = m_strb_q;
      tcnt_d      = tcnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      rsp_to_d    = rsp_to_q;

      unique case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
               if (head.addr[1:0] != 2'b00) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b1;
                  rsp_to_d    = 1'b0;
                  err_inc     = 1'b1;
                  state_d     = RSP;
               end else begin
                  m_req_d   = 1'b1;
                  m_wr_d    = head.wr;
                  m_addr_d  = head.addr;
                  m_wdata_d = head.wdata;
                  m_strb_d  = head.strb;
                  tcnt_d    = '0;
                  state_d   = REQ;
               end
            end
         end
         REQ: begin
            // An ack on the last allowed cycle still completes normally.
            if (bus.m_ack) begin
               m_req_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = (m_wr_q || bus.m_err) ? '0 : bus.m_rdata;
               rsp_err_d   = bus.m_err;
               rsp_to_d    = 1'b0;
               err_inc     = bus.m_err;
               state_d     = RSP;
            end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
               m_req_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_to_d    = 1'b1;
               err_inc     = 1'b1;
               state_d     = RSP;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         RSP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);

      cmd_ready_d = (count_d != CNT_W'(CMD_DEPTH));
      busy_d      = (count_d != '0) || (state_d != IDLE);
      err_cnt_d   = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b1;
         m_req_q     <= 1'b0;
         m_wr_q      <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         m_strb_q    <= '0;
         tcnt_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_to_q    <= 1'b0;
         busy_q      <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q     <= count_d;
         cmd_ready_q <= cmd_ready_d;
         m_req_q     <= m_req_d;
         m_wr_q      <= m_wr_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         m_strb_q    <= m_strb_d;
         tcnt_q      <= tcnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_to_q    <= rsp_to_d;
         busy_q      <= busy_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.m_req       = m_req_q;
   assign bus.m_wr        = m_wr_q;
   assign bus.m_addr      = m_addr_q;
   assign bus.m_wdata     = m_wdata_q;
   assign bus.m_strb      = m_strb_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_to_q;
   assign busy            = busy_q;
   assign err_count       = err_cnt_q;
endmodule
